// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined reduction tree: the mode encoding,
// the padding identity for each mode, the pairwise combine operator and
// the sizing helpers used to work out how many levels there are and how
// wide each one is.
package reduce_pkg;

  localparam logic [1:0] MODE_AND  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_NAND = 2'd2;
  localparam logic [1:0] MODE_NOR  = 2'd3;

  // Padding value that leaves a pairwise result unchanged.
  function automatic logic identity_bit(input logic [1:0] mode);
    logic id;
    case (mode)
      MODE_AND, MODE_NAND: id = 1'b1;
      MODE_OR,  MODE_NOR:  id = 1'b0;
      default:             id = 1'b1;
    endcase
    return id;
  endfunction

  // Non-inverting pairwise operator.
  // The inversion for NAND/NOR is applied only by the final level.
  function automatic logic combine(input logic a, input logic b, input logic [1:0] mode);
    logic r;
    case (mode)
      MODE_AND, MODE_NAND: r = a & b;
      MODE_OR,  MODE_NOR:  r = a | b;
      default:             r = a & b;
    endcase
    return r;
  endfunction

  // Returns the smallest r such that 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Returns the number of live bits entering level lvl,
  // which is ceil(n / 2**lvl).
  function automatic int level_width(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_level.sv
// One registered level of the reduction tree.
// It folds W bits into ceil(W/2) bits by pairing bit 2j with bit 2j+1. An
// odd tail bit is paired with the identity value for the current mode.
// The FINAL level also applies the NAND/NOR output inversion.
// Data and mode load only when a valid item moves in. A bubble therefore
// leaves the previous payload untouched.
module reduce_level
  import reduce_pkg::*;
#(
  parameter int W     = 2,
  parameter bit FINAL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  output logic [(W+1)/2-1:0]     out_data,
  output logic [1:0]             out_mode
);

  localparam int OW = (W + 1) / 2;

  logic [2*OW-1:0] padded_s;
  logic [OW-1:0]   pair_s;
  logic [OW-1:0]   next_data_s;
  logic            valid_r;
  logic [OW-1:0]   data_r;
  logic [1:0]      mode_r;

  // Pad to an even width with the mode identity, then reduce each pair.
  always_comb begin
    padded_s         = {(2*OW){identity_bit(in_mode)}};
    padded_s[W-1:0]  = in_data;
    pair_s           = '0;
    for (int j = 0; j < OW; j++) begin
      pair_s[j] = combine(padded_s[2*j], padded_s[2*j+1], in_mode);
    end
    if (FINAL && (in_mode == MODE_NAND || in_mode == MODE_NOR)) begin
      next_data_s = ~pair_s;
    end else begin
      next_data_s = pair_s;
    end
  end

  // Level register: valid follows every advance, payload only real items.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      mode_r  <= 2'd0;
    end else if (en) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= next_data_s;
        mode_r <= in_mode;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_mode  = mode_r;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N_IN-input AND/OR/NAND/NOR reduction tree with valid/ready on
// both sides.
// The pipe has clog2(N_IN) registered levels, and all of them stall together.
// Optional feature macro: REDUCE_TREE_COUNT_EN. It adds hit_count, a
// saturating count of output handshakes that deliver a 1.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int N_IN = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  output logic [1:0]      out_mode
`ifdef REDUCE_TREE_COUNT_EN
  ,
  output logic [15:0]     hit_count
`endif
);

  localparam int LEVELS = clog2(N_IN);

  logic            adv_s;
  logic [N_IN-1:0] lvl_data_s  [0:LEVELS];
  logic            lvl_valid_s [0:LEVELS];
  logic [1:0]      lvl_mode_s  [0:LEVELS];
  logic            unused_top_s;

  // The pipe moves whenever the output slot is free or is being drained.
  assign adv_s    = out_ready | ~out_valid;
  assign in_ready = adv_s;

  assign lvl_data_s[0]  = in_data;
  assign lvl_valid_s[0] = in_valid;
  assign lvl_mode_s[0]  = in_mode;

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int WI = level_width(N_IN, i);
    localparam int WO = level_width(N_IN, i + 1);

    reduce_level #(
      .W     (WI),
      .FINAL (i == LEVELS - 1)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv_s),
      .in_valid  (lvl_valid_s[i]),
      .in_data   (lvl_data_s[i][WI-1:0]),
      .in_mode   (lvl_mode_s[i]),
      .out_valid (lvl_valid_s[i+1]),
      .out_data  (lvl_data_s[i+1][WO-1:0]),
      .out_mode  (lvl_mode_s[i+1])
    );

    assign lvl_data_s[i+1][N_IN-1:WO] = '0;

    if (WI < N_IN) begin : g_pad
      logic unused_pad_s;
      assign unused_pad_s = ^lvl_data_s[i][N_IN-1:WI];
    end
  end

  assign unused_top_s = ^lvl_data_s[LEVELS][N_IN-1:1];

  assign out_valid = lvl_valid_s[LEVELS];
  assign out_data  = lvl_data_s[LEVELS][0];
  assign out_mode  = lvl_mode_s[LEVELS];

`ifdef REDUCE_TREE_COUNT_EN
  logic [15:0] hit_count_r;

  // Count delivered 1-results, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_r <= 16'd0;
    end else if (out_valid && out_ready && out_data && (hit_count_r != 16'hFFFF)) begin
      hit_count_r <= hit_count_r + 16'd1;
    end
  end

  assign hit_count = hit_count_r;
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Self-checking bench for reduce_tree_pipe.
// It instantiates two DUTs: N_IN=16 (4 levels) and N_IN=5 (3 levels).
// Expected results come from whole-vector reductions in the bench.
// Define REDUCE_TREE_COUNT_EN to also exercise hit_count.
module tb_reduce_tree_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_data;
  logic [15:0] in_data;
  logic [1:0]  in_mode, out_mode;
  logic        in_valid5, in_ready5, out_valid5, out_ready5, out_data5;
  logic [4:0]  in_data5;
  logic [1:0]  in_mode5, out_mode5;
`ifdef REDUCE_TREE_COUNT_EN
  logic [15:0] hit_count, hit_count5;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic d; logic [1:0] m; } exp_t;
  exp_t q16[$];

  always #5 clk = ~clk;

  reduce_tree_pipe #(.N_IN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
`ifdef REDUCE_TREE_COUNT_EN
    , .hit_count(hit_count)
`endif
  );

  reduce_tree_pipe #(.N_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .in_mode(in_mode5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_data(out_data5), .out_mode(out_mode5)
`ifdef REDUCE_TREE_COUNT_EN
    , .hit_count(hit_count5)
`endif
  );

  // Reference model.
  // AND means every bit is set, OR means any bit is set, and modes 2/3 invert.
  function automatic logic ref16(input logic [15:0] d, input logic [1:0] m);
    logic r;
    r = m[0] ? (d != 16'h0000) : (d == 16'hFFFF);
    return m[1] ? ~r : r;
  endfunction

  function automatic logic ref5(input logic [4:0] d, input logic [1:0] m);
    logic r;
    r = m[0] ? (d != 5'b00000) : (d == 5'b11111);
    return m[1] ? ~r : r;
  endfunction

  // Biased data: near-all-ones and near-zero vectors make AND/OR results interesting.
  function automatic logic [15:0] pick16();
    logic [15:0] one;
    one = 16'h0001 << $urandom_range(0, 15);
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'hFFFF ^ one;
      2: return 16'h0000;
      3: return one;
      default: return 16'($urandom);
    endcase
  endfunction

  // Apply one cycle of stimulus after the falling edge and sample the outputs 1 ns later.
  task automatic drive16(input logic v, input logic [15:0] d, input logic [1:0] m, input logic ordy,
                         output logic ir, output logic ov, output logic od, output logic [1:0] om);
    @(negedge clk);
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy;
    #1;
    ir = in_ready; ov = out_valid; od = out_data; om = out_mode;
  endtask

  task automatic drive5(input logic v, input logic [4:0] d, input logic [1:0] m,
                        output logic ov, output logic od, output logic [1:0] om);
    @(negedge clk);
    in_valid5 = v; in_data5 = d; in_mode5 = m; out_ready5 = 1'b1;
    #1;
    ov = out_valid5; od = out_data5; om = out_mode5;
  endtask

  task automatic test_reset();
    logic ir, ov, od;
    logic [1:0] om;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 16'h0; in_mode = 2'd0; out_ready = 1'b1;
    in_valid5 = 1'b0; in_data5 = 5'h0; in_mode5 = 2'd0; out_ready5 = 1'b1;
    #23 rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive16(1'b0, 16'h0, 2'd0, 1'b1, ir, ov, od, om);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
      checks++; if (od !== 1'b0) begin errors++; $display("FAIL reset_out_data: got %b expected 0", od); end
      checks++; if (om !== 2'd0) begin errors++; $display("FAIL reset_out_mode: got %0d expected 0", om); end
      checks++; if (ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir); end
      checks++; if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1) begin
        errors++; $display("FAIL reset_dut5: got valid=%b ready=%b expected 0/1", out_valid5, in_ready5);
      end
    end
  endtask

  logic [15:0] dir_d [5];
  logic [1:0]  dir_m [5];
  logic        dir_e [5];

  // Items 0-1: FFFF/FFFE AND. Items 2-4: NOR/OR/NAND. Each should show 4 cycles after its push.
  task automatic test_directed();
    logic ir, ov, od;
    logic [1:0] om;
    dir_d = '{16'hFFFF, 16'hFFFE, 16'h0000, 16'h0100, 16'h0100};
    dir_m = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd2};
    for (int k = 0; k < 5; k++) dir_e[k] = ref16(dir_d[k], dir_m[k]);
    for (int t = 0; t < 12; t++) begin
      if (t < 5) drive16(1'b1, dir_d[t], dir_m[t], 1'b1, ir, ov, od, om);
      else       drive16(1'b0, 16'h0, 2'd0, 1'b1, ir, ov, od, om);
      checks++; if (ir !== 1'b1) begin errors++; $display("FAIL dir_in_ready t=%0d: got %b expected 1", t, ir); end
      checks++; if (ov !== (t >= 4 && t <= 8)) begin
        errors++; $display("FAIL dir_out_valid t=%0d: got %b expected %b", t, ov, (t >= 4 && t <= 8));
      end
      if (t >= 4 && t <= 8) begin
        checks++; if (od !== dir_e[t-4] || om !== dir_m[t-4]) begin
          errors++; $display("FAIL dir_result t=%0d: got %b/%0d expected %b/%0d", t, od, om, dir_e[t-4], dir_m[t-4]);
        end
      end else if (t > 8) begin
        checks++; if (od !== dir_e[4]) begin errors++; $display("FAIL dir_idle_hold t=%0d: got %b expected %b", t, od, dir_e[4]); end
      end
    end
  endtask

  logic [4:0] p5_d [8];
  logic [1:0] p5_m [8];

  // N_IN=5 exercises odd-tail and 2^LEVELS padding; latency is 3.
  task automatic test_pad5();
    logic ov, od;
    logic [1:0] om;
    p5_d[0] = 5'b11111; p5_m[0] = 2'd0;
    p5_d[1] = 5'b01111; p5_m[1] = 2'd0;
    p5_d[2] = 5'b10000; p5_m[2] = 2'd1;
    for (int k = 3; k < 8; k++) begin
      p5_d[k] = ($urandom_range(0, 1) == 0) ? 5'b11111 ^ (5'b00001 << $urandom_range(0, 5)) : 5'($urandom);
      p5_m[k] = 2'($urandom);
    end
    for (int t = 0; t < 12; t++) begin
      if (t < 8) drive5(1'b1, p5_d[t], p5_m[t], ov, od, om);
      else       drive5(1'b0, 5'h0, 2'd0, ov, od, om);
      checks++; if (ov !== (t >= 3 && t <= 10)) begin
        errors++; $display("FAIL pad5_valid t=%0d: got %b expected %b", t, ov, (t >= 3 && t <= 10));
      end
      if (t >= 3 && t <= 10) begin
        checks++; if (od !== ref5(p5_d[t-3], p5_m[t-3]) || om !== p5_m[t-3]) begin
          errors++; $display("FAIL pad5_result t=%0d in=%b: got %b/%0d expected %b/%0d", t, p5_d[t-3], od, om,
                             ref5(p5_d[t-3], p5_m[t-3]), p5_m[t-3]);
        end
      end
    end
  endtask

  // Scoreboarded stream.
  // With plan4=1: 6 items, out_ready low for cycles 5-9. Otherwise: random valid/ready.
  task automatic test_stream(input int n, input bit plan4);
    logic ir, ov, od, ordy, have, prev_hold, prev_od;
    logic [1:0] om, m, prev_om;
    logic [15:0] d;
    exp_t e;
    int sent, cyc;
    sent = 0; cyc = 0; have = 1'b0; prev_hold = 1'b0; prev_od = 1'b0; prev_om = 2'd0;
    d = 16'h0; m = 2'd0;
    while ((sent < n || q16.size() > 0) && cyc < 3000) begin
      if (!have && sent < n && (plan4 || $urandom_range(0, 3) != 0)) begin
        d = pick16(); m = 2'($urandom); have = 1'b1;
      end
      if (plan4) ordy = !(cyc >= 5 && cyc <= 9);
      else       ordy = (sent >= n) ? 1'b1 : 1'($urandom_range(0, 1));
      drive16(have, d, m, ordy, ir, ov, od, om);
      checks++; if (ir !== (ordy | ~ov)) begin
        errors++; $display("FAIL stream_in_ready cyc=%0d: got %b expected %b", cyc, ir, ordy | ~ov);
      end
      if (prev_hold) begin
        checks++; if (ov !== 1'b1 || od !== prev_od || om !== prev_om) begin
          errors++; $display("FAIL stream_hold cyc=%0d: got %b/%b/%0d expected 1/%b/%0d", cyc, ov, od, om, prev_od, prev_om);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (q16.size() == 0) begin
          errors++; $display("FAIL stream_extra cyc=%0d: got output %b expected none", cyc, od);
        end else begin
          e = q16.pop_front();
          if (od !== e.d || om !== e.m) begin
            errors++; $display("FAIL stream_result cyc=%0d: got %b/%0d expected %b/%0d", cyc, od, om, e.d, e.m);
          end
        end
      end
      if (have && ir) begin
        e.d = ref16(d, m); e.m = m; q16.push_back(e); sent++; have = 1'b0;
      end
      prev_hold = ov & ~ordy; prev_od = od; prev_om = om;
      cyc++;
    end
    checks++; if (q16.size() != 0 || sent != n) begin
      errors++; $display("FAIL stream_drain: got sent=%0d pending=%0d expected sent=%0d pending=0", sent, q16.size(), n);
    end
  endtask

  // Assert reset with results stalled in flight. The output must drop at once, and no stale item may reappear.
  task automatic test_reset_midstream();
    logic ir, ov, od;
    logic [1:0] om;
    for (int t = 0; t < 6; t++) drive16(1'b1, 16'hFFFF, 2'd0, 1'b0, ir, ov, od, om);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 1'b0 || out_mode !== 2'd0) begin
      errors++; $display("FAIL midrst_async: got %b/%b/%0d expected 0/0/0", out_valid, out_data, out_mode);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    q16.delete();
    for (int t = 0; t < 8; t++) begin
      drive16(1'b0, 16'h0, 2'd0, 1'b1, ir, ov, od, om);
      checks++; if (ov !== 1'b0 || ir !== 1'b1) begin
        errors++; $display("FAIL midrst_after t=%0d: got valid=%b ready=%b expected 0/1", t, ov, ir);
      end
    end
  endtask

`ifdef REDUCE_TREE_COUNT_EN
  // Push 10 AND results with 7 ones, then enough ones to saturate the counter.
  task automatic test_count();
    logic ir, ov, od;
    logic [1:0] om;
    for (int k = 0; k < 10; k++)
      drive16(1'b1, (k == 3 || k == 6 || k == 9) ? 16'hFFFE : 16'hFFFF, 2'd0, 1'b1, ir, ov, od, om);
    for (int k = 0; k < 6; k++) drive16(1'b0, 16'h0, 2'd0, 1'b1, ir, ov, od, om);
    checks++; if (hit_count !== 16'd7) begin errors++; $display("FAIL count_seven: got %0d expected 7", hit_count); end
    for (int k = 0; k < 65540; k++) drive16(1'b1, 16'h0001, 2'd1, 1'b1, ir, ov, od, om);
    for (int k = 0; k < 6; k++) drive16(1'b0, 16'h0, 2'd0, 1'b1, ir, ov, od, om);
    checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL count_saturate: got %0h expected ffff", hit_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_pad5();
    test_stream(6, 1'b1);
    test_stream(300, 1'b0);
    test_reset_midstream();
`ifdef REDUCE_TREE_COUNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
